// File: rtl/ts_slot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ts_slot_arbiter                                                  |
// | Purpose : Assigns 188-byte TS output slots to the PSI table inserter or    |
// |           the T2-MI source, polices sync/length and pads stalled slots.    |
// |           Define TS_NULL_FILL_EN to fill empty slots with null packets.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ts_slot_arbiter #(
  parameter int T2MI_MAX_WAIT = 4,
  parameter int BYTE_TIMEOUT  = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SLOT_TICK,
  input  logic       TABLE_READY,
  output logic       TABLE_START,
  input  logic [7:0] TABLE_DATA,
  input  logic       TABLE_ENA,
  input  logic       TABLE_PSYNC,
  input  logic       T2MI_READY,
  output logic       T2MI_START,
  input  logic [7:0] T2MI_DATA,
  input  logic       T2MI_ENA,
  input  logic       T2MI_PSYNC,
  output logic [7:0] DATA_OUT,
  output logic       ENA_OUT,
  output logic       PSYNC,
  output logic       ERR_SYNC,
  output logic       ERR_TIMEOUT,
  output logic       ERR_OVERRUN,
  output logic [2:0] state_mon
);

  localparam int c_starv_w = (T2MI_MAX_WAIT < 1) ? 1 : $clog2(T2MI_MAX_WAIT + 1);
  localparam int c_tmo_w   = (BYTE_TIMEOUT < 2) ? 1 : $clog2(BYTE_TIMEOUT + 1);
  localparam logic [c_starv_w-1:0] c_max_wait = c_starv_w'(T2MI_MAX_WAIT);
  localparam logic [c_tmo_w-1:0]   c_tmo_last = c_tmo_w'((BYTE_TIMEOUT < 1) ? 0 : BYTE_TIMEOUT - 1);
  localparam logic [7:0]           c_last_byte = 8'd187;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_PASS  = 3'd2,
    ST_NULL  = 3'd3,
    ST_PAD   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_sel_t2mi;
  logic [7:0]            r_byte_cnt;
  logic [c_starv_w-1:0]  r_starv;
  logic [c_tmo_w-1:0]    r_tmo;
  logic                  r_pad_first;

  logic       w_src_ena;
  logic [7:0] w_src_data;
  logic       w_src_psync;
  logic       w_first;
  logic       w_last;

  assign w_src_ena   = r_sel_t2mi ? T2MI_ENA   : TABLE_ENA;
  assign w_src_data  = r_sel_t2mi ? T2MI_DATA  : TABLE_DATA;
  assign w_src_psync = r_sel_t2mi ? T2MI_PSYNC : TABLE_PSYNC;
  assign w_first     = (r_byte_cnt == 8'd0);
  assign w_last      = (r_byte_cnt == c_last_byte);
  assign state_mon   = r_state;

`ifdef TS_NULL_FILL_EN
  // Null packet: PID 0x1FFF, payload-only, continuity counter 0, all-0xFF body.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    case (idx)
      8'd0:    return 8'h47;
      8'd1:    return 8'h1F;
      8'd2:    return 8'hFF;
      8'd3:    return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_sel_t2mi  <= 1'b0;
      r_byte_cnt  <= 8'd0;
      r_starv     <= '0;
      r_tmo       <= '0;
      r_pad_first <= 1'b0;
      TABLE_START <= 1'b0;
      T2MI_START  <= 1'b0;
      DATA_OUT    <= 8'h00;
      ENA_OUT     <= 1'b0;
      PSYNC       <= 1'b0;
      ERR_SYNC    <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
      ERR_OVERRUN <= 1'b0;
    end else begin
      TABLE_START <= 1'b0;
      T2MI_START  <= 1'b0;
      DATA_OUT    <= 8'h00;
      ENA_OUT     <= 1'b0;
      PSYNC       <= 1'b0;
      ERR_SYNC    <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
      ERR_OVERRUN <= SLOT_TICK && (r_state != ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          if (SLOT_TICK) begin
            r_byte_cnt <= 8'd0;
            if (T2MI_READY && (r_starv >= c_max_wait)) begin
              r_sel_t2mi <= 1'b1;
              r_starv    <= '0;
              r_state    <= ST_GRANT;
            end else if (TABLE_READY) begin
              r_sel_t2mi <= 1'b0;
              if (T2MI_READY && (r_starv < c_max_wait))
                r_starv <= r_starv + 1'b1;
              r_state    <= ST_GRANT;
            end else if (T2MI_READY) begin
              r_sel_t2mi <= 1'b1;
              r_starv    <= '0;
              r_state    <= ST_GRANT;
            end else begin
`ifdef TS_NULL_FILL_EN
              r_state <= ST_NULL;
`else
              r_state <= ST_IDLE;
`endif
            end
          end
        end

        ST_GRANT: begin
          TABLE_START <= !r_sel_t2mi;
          T2MI_START  <= r_sel_t2mi;
          r_byte_cnt  <= 8'd0;
          r_tmo       <= '0;
          r_state     <= ST_PASS;
        end

        ST_PASS: begin
          if (w_src_ena) begin
            ENA_OUT    <= 1'b1;
            DATA_OUT   <= w_src_data;
            PSYNC      <= w_first;
            ERR_SYNC   <= w_first && (!w_src_psync || (w_src_data != 8'h47));
            r_tmo      <= '0;
            r_byte_cnt <= r_byte_cnt + 8'd1;
            if (w_last)
              r_state <= ST_IDLE;
          end else if (r_tmo == c_tmo_last) begin
            // The timeout error is reported alongside the first padding byte.
            r_tmo       <= '0;
            r_pad_first <= 1'b1;
            r_state     <= ST_PAD;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        ST_PAD: begin
          ENA_OUT     <= 1'b1;
          DATA_OUT    <= w_first ? 8'h47 : 8'hFF;
          PSYNC       <= w_first;
          ERR_TIMEOUT <= r_pad_first;
          r_pad_first <= 1'b0;
          r_byte_cnt  <= r_byte_cnt + 8'd1;
          if (w_last)
            r_state <= ST_IDLE;
        end

`ifdef TS_NULL_FILL_EN
        ST_NULL: begin
          ENA_OUT    <= 1'b1;
          DATA_OUT   <= null_byte(r_byte_cnt);
          PSYNC      <= w_first;
          r_byte_cnt <= r_byte_cnt + 8'd1;
          if (w_last)
            r_state <= ST_IDLE;
        end
`endif

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ts_slot_arbiter.sv
`default_nettype none
// Directed bench for ts_slot_arbiter: arbitration, forwarding, padding,
// null fill, sync/overrun errors and mid-packet reset.
module tb_ts_slot_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SLOT_TICK = 1'b0;
  logic       TABLE_READY = 1'b0, TABLE_ENA = 1'b0, TABLE_PSYNC = 1'b0;
  logic       T2MI_READY = 1'b0, T2MI_ENA = 1'b0, T2MI_PSYNC = 1'b0;
  logic [7:0] TABLE_DATA = 8'h00, T2MI_DATA = 8'h00;
  logic       TABLE_START, T2MI_START, ENA_OUT, PSYNC;
  logic       ERR_SYNC, ERR_TIMEOUT, ERR_OVERRUN;
  logic [7:0] DATA_OUT;
  logic [2:0] state_mon;

  int total = 0;
  int bad   = 0;

  ts_slot_arbiter #(.T2MI_MAX_WAIT(4), .BYTE_TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST), .SLOT_TICK(SLOT_TICK),
    .TABLE_READY(TABLE_READY), .TABLE_START(TABLE_START), .TABLE_DATA(TABLE_DATA),
    .TABLE_ENA(TABLE_ENA), .TABLE_PSYNC(TABLE_PSYNC),
    .T2MI_READY(T2MI_READY), .T2MI_START(T2MI_START), .T2MI_DATA(T2MI_DATA),
    .T2MI_ENA(T2MI_ENA), .T2MI_PSYNC(T2MI_PSYNC),
    .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT), .PSYNC(PSYNC),
    .ERR_SYNC(ERR_SYNC), .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_OVERRUN(ERR_OVERRUN),
    .state_mon(state_mon)
  );

  always #5 CLK = ~CLK;

  // Output monitor: captures every valid byte and counts pulses.
  logic [7:0] obuf [0:4095];
  logic       opsy [0:4095];
  int ocnt = 0, n_ts = 0, n_ms = 0, n_sync = 0, n_to = 0, n_ovr = 0;
  int sync_idx = -1, to_idx = -1;

  always @(negedge CLK) begin
    if (ENA_OUT) begin
      obuf[ocnt % 4096] <= DATA_OUT;
      opsy[ocnt % 4096] <= PSYNC;
      ocnt <= ocnt + 1;
    end
    if (TABLE_START) n_ts <= n_ts + 1;
    if (T2MI_START)  n_ms <= n_ms + 1;
    if (ERR_SYNC)    begin n_sync <= n_sync + 1; sync_idx <= ocnt; end
    if (ERR_TIMEOUT) begin n_to <= n_to + 1; to_idx <= ocnt; end
    if (ERR_OVERRUN) n_ovr <= n_ovr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    logic [7:0] v;
    v = i[7:0];
    return v ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ob(input int k);
    return obuf[k % 4096];
  endfunction

  function automatic logic op(input int k);
    return opsy[k % 4096];
  endfunction

  task automatic tick();
    @(negedge CLK); SLOT_TICK = 1'b1;
    @(negedge CLK); SLOT_TICK = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge CLK);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge CLK); #1;
      if (state_mon == 3'd0) break;
    end
    chk("idle_reached", {29'd0, state_mon}, 32'd0);
  endtask

  // Waits for a START pulse, then feeds nbytes from the winner while the
  // other source toggles junk bytes that must be ignored.
  task automatic serve(input int nbytes, input logic [7:0] first, output int who);
    who = -1;
    for (int w = 0; w < 20 && who < 0; w++) begin
      if (TABLE_START) who = 0;
      else if (T2MI_START) who = 1;
      if (who < 0) @(negedge CLK);
    end
    chk("grant_seen", {31'd0, who >= 0}, 32'd1);
    for (int i = 0; i < nbytes && who >= 0; i++) begin
      if (who == 1) begin
        T2MI_ENA = 1'b1; T2MI_DATA = (i == 0) ? first : pat(i); T2MI_PSYNC = (i == 0);
        TABLE_ENA = 1'b1; TABLE_DATA = 8'hEE; TABLE_PSYNC = 1'b0;
      end else begin
        TABLE_ENA = 1'b1; TABLE_DATA = (i == 0) ? first : pat(i); TABLE_PSYNC = (i == 0);
        T2MI_ENA = 1'b1; T2MI_DATA = 8'hEE; T2MI_PSYNC = 1'b0;
      end
      @(negedge CLK);
    end
    TABLE_ENA = 1'b0; TABLE_PSYNC = 1'b0; TABLE_DATA = 8'h00;
    T2MI_ENA  = 1'b0; T2MI_PSYNC  = 1'b0; T2MI_DATA  = 8'h00;
  endtask

  initial begin
    int b, bs, bo, bx, who;
    logic [5:0] exp_m;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_state", {29'd0, state_mon}, 32'd0);
    chk("rst_ena", {31'd0, ENA_OUT}, 32'd0);
    chk("rst_data", {24'd0, DATA_OUT}, 32'd0);
    chk("rst_starts", {30'd0, TABLE_START, T2MI_START}, 32'd0);
    chk("rst_errs", {28'd0, PSYNC, ERR_SYNC, ERR_TIMEOUT, ERR_OVERRUN}, 32'd0);
    RST = 1'b0;
    settle();

    // Table only: START latency, full packet forwarded
    TABLE_READY = 1'b1;
    b = ocnt; bs = n_ts;
    tick();
    chk("start_early", {31'd0, TABLE_START}, 32'd0);
    @(negedge CLK);
    chk("start_latency", {31'd0, TABLE_START}, 32'd1);
    serve(188, 8'h47, who);
    chk("t1_owner", who, 32'd0);
    wait_idle(20);
    settle();
    chk("t1_count", ocnt - b, 32'd188);
    chk("t1_start_once", n_ts - bs, 32'd1);
    chk("t1_byte0", {24'd0, ob(b)}, 32'h47);
    chk("t1_psync0", {31'd0, op(b)}, 32'd1);
    chk("t1_psync1", {31'd0, op(b + 1)}, 32'd0);
    chk("t1_byte50", {24'd0, ob(b + 50)}, {24'd0, pat(50)});
    chk("t1_byte187", {24'd0, ob(b + 187)}, {24'd0, pat(187)});

    // Both ready for 6 slots: T,T,T,T,M,T
    T2MI_READY = 1'b1;
    exp_m = 6'b010000;
    for (int s = 0; s < 6; s++) begin
      tick();
      serve(188, 8'h47, who);
      chk($sformatf("arb_slot%0d", s), who, {31'd0, exp_m[s]});
      wait_idle(20);
    end

    // Source stalls after 100 bytes -> timeout and 0xFF padding
    T2MI_READY = 1'b0;
    settle();
    b = ocnt; bo = n_to;
    tick();
    serve(100, 8'h47, who);
    wait_idle(700);
    settle();
    chk("to_count", ocnt - b, 32'd188);
    chk("to_pulse", n_to - bo, 32'd1);
    chk("to_align", to_idx, b + 100);
    chk("to_byte99", {24'd0, ob(b + 99)}, {24'd0, pat(99)});
    chk("to_byte100", {24'd0, ob(b + 100)}, 32'hFF);
    chk("to_byte187", {24'd0, ob(b + 187)}, 32'hFF);

    // Stall before any byte -> padded packet still starts with 0x47/PSYNC
    b = ocnt;
    tick();
    serve(0, 8'h47, who);
    wait_idle(700);
    settle();
    chk("pad0_count", ocnt - b, 32'd188);
    chk("pad0_byte0", {24'd0, ob(b)}, 32'h47);
    chk("pad0_psync0", {31'd0, op(b)}, 32'd1);
    chk("pad0_byte1", {24'd0, ob(b + 1)}, 32'hFF);

    // Empty slot
    TABLE_READY = 1'b0;
    b = ocnt; bs = n_ts + n_ms;
    tick();
`ifdef TS_NULL_FILL_EN
    chk("null_state", {29'd0, state_mon}, 32'd3);
    wait_idle(400);
    settle();
    chk("null_count", ocnt - b, 32'd188);
    chk("null_b0", {24'd0, ob(b)}, 32'h47);
    chk("null_b1", {24'd0, ob(b + 1)}, 32'h1F);
    chk("null_b2", {24'd0, ob(b + 2)}, 32'hFF);
    chk("null_b3", {24'd0, ob(b + 3)}, 32'h10);
    chk("null_b187", {24'd0, ob(b + 187)}, 32'hFF);
    chk("null_psync", {30'd0, op(b), op(b + 1)}, 32'd2);
`else
    repeat (5) @(negedge CLK);
    chk("empty_state", {29'd0, state_mon}, 32'd0);
    settle();
    chk("empty_no_ena", ocnt - b, 32'd0);
`endif
    chk("empty_no_start", n_ts + n_ms - bs, 32'd0);

    // T2-MI with bad first byte -> ERR_SYNC, PSYNC still set
    T2MI_READY = 1'b1;
    settle();
    b = ocnt; bx = n_sync;
    tick();
    serve(188, 8'h00, who);
    chk("sync_owner", who, 32'd1);
    wait_idle(20);
    settle();
    chk("sync_pulse", n_sync - bx, 32'd1);
    chk("sync_align", sync_idx, b);
    chk("sync_byte0", {24'd0, ob(b)}, 32'h00);
    chk("sync_psync0", {31'd0, op(b)}, 32'd1);

    // Overrun during PASS, then reset mid-packet
    T2MI_READY = 1'b0;
    TABLE_READY = 1'b1;
    tick();
    serve(10, 8'h47, who);
    @(posedge CLK);
    bo = n_ovr; bs = n_ts + n_ms;
    @(negedge CLK); SLOT_TICK = 1'b1;
    @(negedge CLK); SLOT_TICK = 1'b0;
    chk("ovr_pulse", {31'd0, ERR_OVERRUN}, 32'd1);
    @(negedge CLK);
    chk("ovr_single", {31'd0, ERR_OVERRUN}, 32'd0);
    repeat (3) @(negedge CLK);
    chk("ovr_still_pass", {29'd0, state_mon}, 32'd2);
    @(posedge CLK);
    chk("ovr_count", n_ovr - bo, 32'd1);
    chk("ovr_no_start", n_ts + n_ms - bs, 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      TABLE_ENA = 1'b1; TABLE_DATA = pat(10 + i);
      @(negedge CLK);
    end
    RST = 1'b1;
    @(negedge CLK);
    chk("mrst_state", {29'd0, state_mon}, 32'd0);
    chk("mrst_ena", {31'd0, ENA_OUT}, 32'd0);
    chk("mrst_data", {24'd0, DATA_OUT}, 32'd0);
    chk("mrst_flags", {26'd0, PSYNC, ERR_SYNC, ERR_TIMEOUT, ERR_OVERRUN, TABLE_START, T2MI_START}, 32'd0);
    RST = 1'b0; TABLE_ENA = 1'b0; TABLE_READY = 1'b0;
    bs = n_ts + n_ms;
    repeat (10) @(negedge CLK);
    chk("mrst_idle", {29'd0, state_mon}, 32'd0);
    @(posedge CLK);
    chk("mrst_no_start", n_ts + n_ms - bs, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ts_slot_arbiter.md
# ts_slot_arbiter

Schedules the 188-byte output slots of the TS stream between the PSI table inserter and the T2-MI packet source. Sits between those two byte-serial sources and the output stage, and issues each source's START. Fills empty slots with null packets when enabled. Also polices packet length and sync, and pads a stalled source so output slot timing is never lost.

## Interface
Parameters:
- T2MI_MAX_WAIT, 4: consecutive slots a ready T2-MI source may lose to tables before it is forced to win.
- BYTE_TIMEOUT, 255: cycles without an ENA byte from the granted source before the slot is padded.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- SLOT_TICK  in  1  one-cycle pulse; a new 188-byte output slot opens.
- TABLE_READY  in  1  a table packet is pending.
- TABLE_START  out  1  one-cycle grant pulse to the table inserter.
- TABLE_DATA  in  8  table byte.
- TABLE_ENA  in  1  table byte valid.
- TABLE_PSYNC  in  1  first byte of the table packet.
- T2MI_READY  in  1  a full T2-MI TS packet is buffered.
- T2MI_START  out  1  one-cycle grant pulse to the T2-MI source.
- T2MI_DATA  in  8  T2-MI byte.
- T2MI_ENA  in  1  T2-MI byte valid.
- T2MI_PSYNC  in  1  first byte of the T2-MI packet.
- DATA_OUT  out  8  output byte.
- ENA_OUT  out  1  output byte valid.
- PSYNC  out  1  marks byte 0 (0x47) of each output packet.
- ERR_SYNC  out  1  pulse: granted packet's first byte lacked PSYNC or was not 0x47.
- ERR_TIMEOUT  out  1  pulse: slot padded after source stall.
- ERR_OVERRUN  out  1  pulse: SLOT_TICK arrived while not in IDLE.
- state_mon  out  3  current state encoding.

## Operation
- States: IDLE=0, GRANT=1, PASS=2, NULL=3, PAD=4.
- Reset values:
  - All outputs 0.
  - state=IDLE, byte counter=0, starvation counter=0, timeout counter=0, sel=table.
- IDLE: on SLOT_TICK, choose the slot owner:
  - T2MI_READY && starvation counter ≥ T2MI_MAX_WAIT → T2-MI.
  - else TABLE_READY → table; starvation counter +1 if T2MI_READY, saturating at T2MI_MAX_WAIT.
  - else T2MI_READY → T2-MI.
  - else → NULL state.
  - Whenever T2-MI is served, the starvation counter clears.
- GRANT: pulse the selected START for exactly one cycle, clear the byte and timeout counters, go to PASS.
- PASS:
  - Each selected-source ENA byte is forwarded and increments the 8-bit byte counter.
  - Byte 0 must have PSYNC=1 and data 0x47; otherwise pulse ERR_SYNC and still forward the byte.
  - Byte 0 drives PSYNC on the output, whatever the input PSYNC was.
  - After byte 187, go to IDLE.
  - The unselected source's ENA is ignored. Selected-source bytes arriving in IDLE are dropped.
- Timeout: in PASS, the timeout counter increments on each cycle with no selected ENA and clears on each ENA. Reaching BYTE_TIMEOUT pulses ERR_TIMEOUT and moves to PAD.
- PAD: emits 0xFF, one byte per cycle, until the byte counter completes 188; then IDLE. If no bytes were forwarded before the stall, byte 0 is 0x47 with PSYNC.
- NULL: emits 47 1F FF 10 followed by 184×FF, one byte per cycle, PSYNC on byte 0; then IDLE.
- SLOT_TICK outside IDLE: pulse ERR_OVERRUN; the tick is discarded and not queued.
- Simultaneous SLOT_TICK and new READY in the same cycle: READY is sampled in that cycle.
- RST mid-packet: return to IDLE the next cycle with outputs 0; the partial packet is not completed.

## Timing
- SLOT_TICK at cycle n → START high at n+2 (IDLE→GRANT at n+1).
- Forwarding latency: 1 cycle (source byte at cycle k → DATA_OUT/ENA_OUT at k+1).
- NULL/PAD bytes start the cycle after the state entry.
- ERR_* outputs are registered and aligned with the offending output byte.
- Back-to-back: IDLE is re-entered the cycle after the last byte, so a SLOT_TICK in that cycle is accepted.

## Configuration
- TS_NULL_FILL_EN defined: empty slots produce null packets as above.
- TS_NULL_FILL_EN undefined:
  - The NULL state and its generator are compiled out; an empty slot leaves ENA_OUT low and stays in IDLE.
  - PAD still emits 0xFF.

## Test plan
- TABLE_READY only, SLOT_TICK → TABLE_START at +2; 188 bytes forwarded, first byte 0x47 with PSYNC; state returns to 0.
- Both READY held for 6 slots, T2MI_MAX_WAIT=4 → grants T,T,T,T,M,T.
- Granted source stops after 100 bytes, BYTE_TIMEOUT=255 → ERR_TIMEOUT pulse; 88 bytes of 0xFF; 188 output bytes total.
- No READY, SLOT_TICK → 47 1F FF 10 + 184×FF with TS_NULL_FILL_EN; no ENA_OUT without it.
- First T2-MI byte 0x00 → ERR_SYNC pulse; PSYNC out still high on byte 0.
- SLOT_TICK during PASS → ERR_OVERRUN; no extra START; RST asserted mid-PASS → IDLE with all outputs 0.
